// File: rtl/interface_sensor_serial.sv
// Sensor trigger + N-byte UART reply receiver with parity/framing checks, timeout and retries; reply visible 2 clocks after last stop sample.
// No backpressure: medir is ignored while busy. Define INTERFACE_SENSOR_CHECKSUM_EN to require the last byte be the mod-256 sum of the others.
module interface_sensor_serial #(
    parameter int CLOCK_FREQ     = 50_000_000,
    parameter int BAUD           = 9600,
    parameter int N_BYTES        = 4,
    parameter int PARITY_MODE    = 1,
    parameter int TRIGGER_CYCLES = 1000,
    parameter int TIMEOUT_CYCLES = 10_000_000,
    parameter int MAX_RETRIES    = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   medir,
    input  logic                   rx_serial,
    output logic                   medir_out,
    output logic [8*N_BYTES-1:0]   dados_out,
    output logic                   pronto_medida,
    output logic                   erro_medida,
    output logic                   ocupado,
    output logic [3:0]             db_estado
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD;
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int TW = $clog2(TRIGGER_CYCLES + 1);
    localparam int OW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam int BW = $clog2(N_BYTES + 1);

    localparam logic [CW-1:0] HALF_C    = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] FULL_C    = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TRIG_LAST = TW'(TRIGGER_CYCLES - 1);
    localparam logic [OW-1:0] TOUT_LAST = OW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
    localparam logic [BW-1:0] NB_C      = BW'(N_BYTES);
    // Frame slot index: 0 start, 1..8 data, 9 parity (if enabled), then stop
    localparam logic [3:0]    STOP_IDX  = (PARITY_MODE != 0) ? 4'd10 : 4'd9;

    typedef enum logic [3:0] {
        OCIOSO   = 4'd0,
        DISPARA  = 4'd1,
        AGUARDA  = 4'd2,
        RECEBE   = 4'd3,
        VERIFICA = 4'd4,
        FINAL    = 4'd5,
        FALHA    = 4'd6
    } estado_t;

    estado_t               estado_q, estado_d;
    logic                  rx_meta_q, rx_sync_q, rx_prev_q;
    logic [TW-1:0]         trig_q, trig_d;
    logic [OW-1:0]         tout_q, tout_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [3:0]            bit_idx_q, bit_idx_d;
    logic [7:0]            shift_q, shift_d;
    logic                  par_err_q, par_err_d;
    logic [BW-1:0]         byte_cnt_q, byte_cnt_d;
    logic [RW-1:0]         retry_q, retry_d;
    logic [8*N_BYTES-1:0]  asm_q, asm_d;
    logic [8*N_BYTES-1:0]  dados_q, dados_d;

    logic                  rx_fall;
    logic                  par_exp;
    logic                  cks_ok;
    logic [CW-1:0]         limit;

    assign rx_fall = rx_prev_q & ~rx_sync_q;
    assign par_exp = (PARITY_MODE == 2) ? ^shift_q : ~^shift_q;
    assign limit   = (bit_idx_q == 4'd0) ? HALF_C : FULL_C;

`ifdef INTERFACE_SENSOR_CHECKSUM_EN
    logic [7:0] cks_sum;
    always_comb begin
        cks_sum = 8'd0;
        for (int i = 1; i < N_BYTES; i++) begin
            cks_sum = cks_sum + asm_q[8*i +: 8];
        end
        cks_ok = (cks_sum == asm_q[7:0]);
    end
`else
    assign cks_ok = 1'b1;
`endif

    always_comb begin
        estado_d      = estado_q;
        trig_d        = trig_q;
        tout_d        = tout_q;
        bit_cnt_d     = bit_cnt_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        par_err_d     = par_err_q;
        byte_cnt_d    = byte_cnt_q;
        retry_d       = retry_q;
        asm_d         = asm_q;
        dados_d       = dados_q;
        medir_out     = 1'b0;
        pronto_medida = 1'b0;
        erro_medida   = 1'b0;

        case (estado_q)
            OCIOSO: begin
                if (medir) begin
                    estado_d = DISPARA;
                    retry_d  = '0;
                end
            end
            DISPARA: begin
                medir_out = 1'b1;
                if (trig_q == TRIG_LAST) begin
                    estado_d   = AGUARDA;
                    trig_d     = '0;
                    byte_cnt_d = '0;
                    tout_d     = '0;
                    asm_d      = '0;
                end else begin
                    trig_d = trig_q + TW'(1);
                end
            end
            AGUARDA: begin
                if (rx_fall) begin
                    estado_d  = RECEBE;
                    bit_cnt_d = '0;
                    bit_idx_d = 4'd0;
                    par_err_d = 1'b0;
                end else if (tout_q == TOUT_LAST) begin
                    estado_d = FALHA;
                end else begin
                    tout_d = tout_q + OW'(1);
                end
            end
            RECEBE: begin
                if (bit_cnt_q != limit) begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end else begin
                    bit_cnt_d = '0;
                    bit_idx_d = bit_idx_q + 4'd1;
                    if (bit_idx_q == 4'd0) begin
                        // Line high at mid start bit: glitch, keep the timeout running
                        if (rx_sync_q) estado_d = AGUARDA;
                    end else if (bit_idx_q <= 4'd8) begin
                        shift_d = {rx_sync_q, shift_q[7:1]};
                    end else if (bit_idx_q != STOP_IDX) begin
                        par_err_d = (rx_sync_q != par_exp);
                    end else if (!rx_sync_q || par_err_q) begin
                        estado_d = FALHA;
                    end else begin
                        asm_d      = (8*N_BYTES)'({asm_q, shift_q});
                        byte_cnt_d = byte_cnt_q + BW'(1);
                        tout_d     = '0;
                        estado_d   = ((byte_cnt_q + BW'(1)) == NB_C) ? VERIFICA : AGUARDA;
                    end
                end
            end
            VERIFICA: begin
                if (cks_ok) begin
                    estado_d = FINAL;
                    dados_d  = asm_q;
                end else begin
                    estado_d = FALHA;
                end
            end
            FINAL: begin
                pronto_medida = 1'b1;
                estado_d      = OCIOSO;
            end
            FALHA: begin
                if (retry_q < RETRY_MAX) begin
                    retry_d  = retry_q + RW'(1);
                    estado_d = DISPARA;
                end else begin
                    erro_medida = 1'b1;
                    estado_d    = OCIOSO;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            trig_q     <= '0;
            tout_q     <= '0;
            bit_cnt_q  <= '0;
            bit_idx_q  <= 4'd0;
            shift_q    <= 8'd0;
            par_err_q  <= 1'b0;
            byte_cnt_q <= '0;
            retry_q    <= '0;
            asm_q      <= '0;
            dados_q    <= '0;
        end else begin
            estado_q   <= estado_d;
            rx_meta_q  <= rx_serial;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            trig_q     <= trig_d;
            tout_q     <= tout_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            par_err_q  <= par_err_d;
            byte_cnt_q <= byte_cnt_d;
            retry_q    <= retry_d;
            asm_q      <= asm_d;
            dados_q    <= dados_d;
        end
    end

    assign dados_out = dados_q;
    assign ocupado   = (estado_q != OCIOSO);
    assign db_estado = estado_q;

endmodule

// File: tb/tb_interface_sensor_serial.sv
// Bench for interface_sensor_serial: randomized UART replies scored against a byte-level model of the reply.
module tb_interface_sensor_serial;

    localparam int CF   = 1_000_000;
    localparam int BD   = 62_500;
    localparam int CPB  = CF / BD;
    localparam int TRIG = 20;
    localparam int TOUT = 2000;
    localparam int MR   = 2;
    localparam int PM   = 1;
`ifdef INTERFACE_SENSOR_CHECKSUM_EN
    localparam int NB   = 5;
    localparam int CKS  = 1;
`else
    localparam int NB   = 4;
    localparam int CKS  = 0;
`endif
    localparam int NPAY = NB - CKS;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              medir = 1'b0;
    logic              rx_serial = 1'b1;
    logic              medir_out;
    logic [8*NB-1:0]   dados_out;
    logic              pronto_medida;
    logic              erro_medida;
    logic              ocupado;
    logic [3:0]        db_estado;

    interface_sensor_serial #(
        .CLOCK_FREQ(CF), .BAUD(BD), .N_BYTES(NB), .PARITY_MODE(PM),
        .TRIGGER_CYCLES(TRIG), .TIMEOUT_CYCLES(TOUT), .MAX_RETRIES(MR)
    ) dut (
        .clock(clock), .reset(reset), .medir(medir), .rx_serial(rx_serial),
        .medir_out(medir_out), .dados_out(dados_out), .pronto_medida(pronto_medida),
        .erro_medida(erro_medida), .ocupado(ocupado), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int n_trig = 0, n_pronto = 0, n_erro = 0;
    logic mo_prev = 1'b0;
    logic [7:0] reply[$];
    logic [8*NB-1:0] last_good = '0;

    always @(negedge clock) begin
        if (medir_out && !mo_prev) n_trig++;
        mo_prev = medir_out;
        if (pronto_medida) n_pronto++;
        if (erro_medida) n_erro++;
    end

    // Odd parity: total ones in data+parity is odd
    function automatic logic par_bit(input logic [7:0] b);
        int ones;
        ones = $countones(b);
        return (PM == 2) ? logic'(ones % 2) : logic'((ones % 2) == 0);
    endfunction

    function automatic logic [8*NB-1:0] expect_val();
        logic [8*NB-1:0] v;
        v = '0;
        foreach (reply[i]) v = {v[8*NB-9:0], reply[i]};
        return v;
    endfunction

    task automatic finish_reply();
`ifdef INTERFACE_SENSOR_CHECKSUM_EN
        int s;
        s = 0;
        foreach (reply[i]) s += int'(reply[i]);
        reply.push_back(s[7:0]);
`endif
    endtask

    task automatic random_reply();
        reply.delete();
        for (int i = 0; i < NPAY; i++) reply.push_back(8'($urandom_range(0, 255)));
        finish_reply();
    endtask

    task automatic hold_bit(input logic v);
        rx_serial = v;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(b[i]);
        hold_bit(par_bit(b) ^ bad_par);
        hold_bit(~bad_stop);
        rx_serial = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic send_reply();
        foreach (reply[i]) send_byte(reply[i], 1'b0, 1'b0);
    endtask

    task automatic pulse_medir();
        @(negedge clock) medir = 1'b1;
        @(negedge clock) medir = 1'b0;
    endtask

    task automatic wait_trig_fall(input string tag);
        int t;
        t = 0;
        while (!medir_out && t < 8000) begin @(negedge clock); t++; end
        while (medir_out && t < 8000) begin @(negedge clock); t++; end
        if (t >= 8000) begin
            checks++; errors++;
            $display("FAIL %s: medir_out pulse not seen within 8000 cycles", tag);
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic wait_pronto(output bit ok);
        int t;
        t = 0;
        ok = 0;
        while (t < 6000 && !ok) begin
            @(negedge clock);
            t++;
            if (pronto_medida) ok = 1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++;
        if ({medir_out, pronto_medida, erro_medida, ocupado} !== 4'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {medir_out, pronto_medida, erro_medida, ocupado});
        end
        checks++;
        if (dados_out !== '0) begin errors++; $display("FAIL reset_dados: got %h want 0", dados_out); end
        checks++;
        if (db_estado !== 4'd0) begin errors++; $display("FAIL reset_estado: got %0d want 0", db_estado); end
        reset = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_basic();
        int bt, bp, be, w;
        bit ok;
        bt = n_trig; bp = n_pronto; be = n_erro;
        reply = '{8'hBA, 8'hDE, 8'h12, 8'h34};
        finish_reply();
        pulse_medir();
        checks++;
        if (medir_out !== 1'b1) begin errors++; $display("FAIL trig_rise: medir_out %b want 1 one cycle after medir", medir_out); end
        w = 0;
        while (medir_out && w < 5000) begin w++; @(negedge clock); end
        checks++;
        if (w != TRIG) begin errors++; $display("FAIL trig_width: got %0d want %0d", w, TRIG); end
        repeat (3) @(negedge clock);
        fork
            send_reply();
            wait_pronto(ok);
        join
        checks++;
        if (!ok || dados_out !== expect_val()) begin
            errors++; $display("FAIL basic_dados: got %h want %h (pronto %0d)", dados_out, expect_val(), ok);
        end
        last_good = expect_val();
        @(negedge clock);
        checks++;
        if (ocupado !== 1'b0) begin errors++; $display("FAIL basic_ocupado_fall: got %b want 0", ocupado); end
        repeat (5) @(negedge clock);
        checks++;
        if (n_pronto - bp != 1 || n_erro - be != 0 || n_trig - bt != 1) begin
            errors++; $display("FAIL basic_counts: pronto %0d erro %0d trig %0d want 1 0 1", n_pronto - bp, n_erro - be, n_trig - bt);
        end
    endtask

    task automatic test_random();
        bit ok;
        for (int it = 0; it < 3; it++) begin
            random_reply();
            pulse_medir();
            wait_trig_fall("random_trig");
            fork
                send_reply();
                wait_pronto(ok);
            join
            checks++;
            if (!ok || dados_out !== expect_val()) begin
                errors++; $display("FAIL random_dados[%0d]: got %h want %h", it, dados_out, expect_val());
            end else last_good = expect_val();
            repeat (4) @(negedge clock);
        end
    endtask

    task automatic test_parity_retry();
        int bt, be;
        bit ok;
        bt = n_trig; be = n_erro;
        pulse_medir();
        wait_trig_fall("parity_trig1");
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h02, 1'b1, 1'b0);
        wait_trig_fall("parity_trig2");
        reply = '{8'h01, 8'h02, 8'h03, 8'h04};
        finish_reply();
        fork
            send_reply();
            wait_pronto(ok);
        join
        checks++;
        if (!ok || dados_out !== expect_val()) begin
            errors++; $display("FAIL parity_dados: got %h want %h", dados_out, expect_val());
        end else last_good = expect_val();
        repeat (4) @(negedge clock);
        checks++;
        if (n_trig - bt != 2 || n_erro != be) begin
            errors++; $display("FAIL parity_trigs: trig %0d erro %0d want 2 0", n_trig - bt, n_erro - be);
        end
    endtask

    task automatic test_framing_glitch();
        int bt, bp, be;
        bit ok;
        bt = n_trig;
        pulse_medir();
        wait_trig_fall("frame_trig1");
        send_byte(8'h5A, 1'b0, 1'b1);
        wait_trig_fall("frame_trig2");
        checks++;
        if (n_trig - bt != 2) begin errors++; $display("FAIL frame_retry: trig %0d want 2", n_trig - bt); end
        bp = n_pronto; be = n_erro;
        repeat (5) @(negedge clock);
        rx_serial = 1'b0;
        @(negedge clock) rx_serial = 1'b1;
        repeat (CPB) @(negedge clock);
        checks++;
        if (db_estado !== 4'd2 || n_pronto != bp || n_erro != be) begin
            errors++; $display("FAIL glitch_state: estado %0d want 2", db_estado);
        end
        random_reply();
        fork
            send_reply();
            wait_pronto(ok);
        join
        checks++;
        if (!ok || dados_out !== expect_val() || n_trig - bt != 2) begin
            errors++; $display("FAIL glitch_dados: got %h want %h trig %0d", dados_out, expect_val(), n_trig - bt);
        end else last_good = expect_val();
        repeat (4) @(negedge clock);
    endtask

    task automatic test_timeout();
        int bt, bp, be, t;
        bt = n_trig; bp = n_pronto; be = n_erro;
        pulse_medir();
        t = 0;
        while (!erro_medida && t < 10000) begin @(negedge clock); t++; end
        checks++;
        if (!erro_medida) begin errors++; $display("FAIL timeout_erro: erro_medida not seen in 10000 cycles"); end
        repeat (3) @(negedge clock);
        checks++;
        if (n_trig - bt != MR + 1 || n_erro - be != 1 || n_pronto != bp) begin
            errors++; $display("FAIL timeout_counts: trig %0d erro %0d pronto %0d want %0d 1 0", n_trig - bt, n_erro - be, n_pronto - bp, MR + 1);
        end
        checks++;
        if (dados_out !== last_good || ocupado !== 1'b0) begin
            errors++; $display("FAIL timeout_dados: got %h want %h ocupado %b", dados_out, last_good, ocupado);
        end
    endtask

    task automatic test_reset_busy();
        int bt;
        bit ok;
        pulse_medir();
        wait_trig_fall("rst_trig");
        rx_serial = 1'b0;
        repeat (CPB + 4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({medir_out, pronto_medida, erro_medida, ocupado} !== 4'b0 || dados_out !== '0 || db_estado !== 4'd0) begin
            errors++; $display("FAIL midreset: flags %b dados %h estado %0d want 0", {medir_out, pronto_medida, erro_medida, ocupado}, dados_out, db_estado);
        end
        reset = 1'b0;
        rx_serial = 1'b1;
        last_good = '0;
        repeat (3) @(negedge clock);
        bt = n_trig;
        pulse_medir();
        repeat (5) @(negedge clock);
        checks++;
        if (ocupado !== 1'b1) begin errors++; $display("FAIL busy_ocupado: got %b want 1", ocupado); end
        pulse_medir();
        wait_trig_fall("busy_trig");
        random_reply();
        fork
            send_reply();
            wait_pronto(ok);
        join
        repeat (TRIG + 10) @(negedge clock);
        checks++;
        if (!ok || dados_out !== expect_val() || n_trig - bt != 1 || db_estado !== 4'd0) begin
            errors++; $display("FAIL busy_ignored: dados %h want %h trig %0d want 1 estado %0d", dados_out, expect_val(), n_trig - bt, db_estado);
        end
    endtask

`ifdef INTERFACE_SENSOR_CHECKSUM_EN
    task automatic test_checksum();
        int bt, bp;
        bit ok;
        reply = '{8'h10, 8'h20, 8'h30, 8'h40, 8'hA0};
        pulse_medir();
        wait_trig_fall("cks_trigA");
        fork
            send_reply();
            wait_pronto(ok);
        join
        checks++;
        if (!ok || dados_out !== expect_val()) begin
            errors++; $display("FAIL cks_good: got %h want %h", dados_out, expect_val());
        end
        repeat (4) @(negedge clock);
        bt = n_trig; bp = n_pronto;
        reply = '{8'h10, 8'h20, 8'h30, 8'h40, 8'hA1};
        pulse_medir();
        wait_trig_fall("cks_trigB1");
        send_reply();
        wait_trig_fall("cks_trigB2");
        checks++;
        if (n_trig - bt != 2 || n_pronto != bp) begin
            errors++; $display("FAIL cks_bad_retry: trig %0d pronto %0d want 2 0", n_trig - bt, n_pronto - bp);
        end
        reply = '{8'h10, 8'h20, 8'h30, 8'h40, 8'hA0};
        fork
            send_reply();
            wait_pronto(ok);
        join
        repeat (4) @(negedge clock);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_parity_retry();
        test_framing_glitch();
        test_timeout();
        test_reset_busy();
`ifdef INTERFACE_SENSOR_CHECKSUM_EN
        test_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
